// File: rtl/brew_sequencer.sv
// brew_sequencer: controls one coffee brew. The sequence is water check, heat,
// brew and dispense. Each timed stage starts the external timer once and waits
// for its expiry flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a start_btn rising edge
// CHECK | one cycle; samples water_ok
// HEAT  | heater on, timer loaded with T_HEAT
// BREW  | heater and pump on, timer loaded with the strength-dependent load
// DISP  | valve on, timer loaded with T_DISP
// ERROR | no water; stays here until cancel_btn is pressed
//
// All outputs come straight from flops. Their next values are derived from the
// next state, so each output changes on the same edge as the state it reflects.
module brew_sequencer #(
    parameter int VAL_W  = 8,
    parameter int T_HEAT = 20,
    parameter int T_DISP = 10
) (
    input  logic             clk_100MHz,
    input  logic             rst_n,
    input  logic             start_btn,
    input  logic             cancel_btn,
    input  logic [1:0]       coffee_sel,
    input  logic             water_ok,
    input  logic             texpired,
    output logic             start_timer,
    output logic [VAL_W-1:0] value,
    output logic             heater_on,
    output logic             pump_on,
    output logic             valve_on,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_HEAT  = 3'd2,
        ST_BREW  = 3'd3,
        ST_DISP  = 3'd4,
        ST_ERROR = 3'd5
    } state_t;

    // A timed state may not react to texpired until this guard has counted down to 0.
    localparam logic [1:0] GUARD_LOAD = 2'd2;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic             start_prev_q, start_prev_d;
    logic [1:0]       guard_q, guard_d;
    logic             start_timer_q, start_timer_d;
    logic [VAL_W-1:0] value_q, value_d;
    logic             heater_q, heater_d;
    logic             pump_q, pump_d;
    logic             valve_q, valve_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;

    logic             start_rise;
    logic             expiry_ok;
    logic [VAL_W-1:0] brew_load;

    assign start_rise = start_btn & ~start_prev_q;
    assign expiry_ok  = texpired && (guard_q == 2'd0);

    // Translate the latched strength selection into the brew timer load.
    always_comb begin
        brew_load = VAL_W'(30);
        case (sel_q)
            2'd0: brew_load = VAL_W'(30);
            2'd1: brew_load = VAL_W'(45);
            2'd2: brew_load = VAL_W'(60);
            2'd3: brew_load = VAL_W'(90);
            default: brew_load = VAL_W'(30);
        endcase
    end

    // Next-state logic and the registered values of all outputs.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        start_prev_d  = start_btn;
        guard_d       = (guard_q != 2'd0) ? guard_q - 2'd1 : 2'd0;
        start_timer_d = 1'b0;
        value_d       = value_q;
        done_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_rise) begin
                    state_d = ST_CHECK;
                    sel_d   = coffee_sel;
                end
            end
            ST_CHECK: begin
                if (cancel_btn)    state_d = ST_IDLE;
                else if (water_ok) state_d = ST_HEAT;
                else               state_d = ST_ERROR;
            end
            ST_HEAT: begin
                if (cancel_btn)     state_d = ST_IDLE;
                else if (expiry_ok) state_d = ST_BREW;
            end
            ST_BREW: begin
                if (cancel_btn)     state_d = ST_IDLE;
                else if (expiry_ok) state_d = ST_DISP;
            end
            ST_DISP: begin
                if (cancel_btn) begin
                    state_d = ST_IDLE;
                end else if (expiry_ok) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_ERROR: begin
                if (cancel_btn) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // On entry to a timed stage: load the timer, pulse start and rearm the guard.
        // value stays constant while the stage lasts and reads 0 outside the timed stages.
        if (state_d != state_q) begin
            case (state_d)
                ST_HEAT: begin
                    value_d       = VAL_W'(T_HEAT);
                    start_timer_d = 1'b1;
                    guard_d       = GUARD_LOAD;
                end
                ST_BREW: begin
                    value_d       = brew_load;
                    start_timer_d = 1'b1;
                    guard_d       = GUARD_LOAD;
                end
                ST_DISP: begin
                    value_d       = VAL_W'(T_DISP);
                    start_timer_d = 1'b1;
                    guard_d       = GUARD_LOAD;
                end
                default: value_d = '0;
            endcase
        end

        heater_d = (state_d == ST_HEAT) || (state_d == ST_BREW);
        pump_d   = (state_d == ST_BREW);
        valve_d  = (state_d == ST_DISP);
        busy_d   = (state_d == ST_CHECK) || (state_d == ST_HEAT) ||
                   (state_d == ST_BREW)  || (state_d == ST_DISP);
        error_d  = (state_d == ST_ERROR);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sel_q         <= 2'd0;
            start_prev_q  <= 1'b0;
            guard_q       <= 2'd0;
            start_timer_q <= 1'b0;
            value_q       <= '0;
            heater_q      <= 1'b0;
            pump_q        <= 1'b0;
            valve_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            start_prev_q  <= start_prev_d;
            guard_q       <= guard_d;
            start_timer_q <= start_timer_d;
            value_q       <= value_d;
            heater_q      <= heater_d;
            pump_q        <= pump_d;
            valve_q       <= valve_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    assign start_timer = start_timer_q;
    assign value       = value_q;
    assign heater_on   = heater_q;
    assign pump_on     = pump_q;
    assign valve_on    = valve_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer. Inputs change 1 ns after a rising edge,
// and outputs are checked at that same point.
module tb_brew_sequencer;

    logic       clk_100MHz = 1'b0;
    logic       rst_n;
    logic       start_btn, cancel_btn, water_ok, texpired;
    logic [1:0] coffee_sel;
    logic       start_timer, heater_on, pump_on, valve_on, busy, done, error;
    logic [7:0] value;

    int checks   = 0;
    int failures = 0;

    brew_sequencer #(.VAL_W(8), .T_HEAT(20), .T_DISP(10)) dut (
        .clk_100MHz (clk_100MHz),
        .rst_n      (rst_n),
        .start_btn  (start_btn),
        .cancel_btn (cancel_btn),
        .coffee_sel (coffee_sel),
        .water_ok   (water_ok),
        .texpired   (texpired),
        .start_timer(start_timer),
        .value      (value),
        .heater_on  (heater_on),
        .pump_on    (pump_on),
        .valve_on   (valve_on),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    int n_st, n_heat, n_brew, n_disp, n_busy, n_done;
    logic [7:0] brew_val;

    initial begin
        rst_n = 1'b0; start_btn = 1'b0; cancel_btn = 1'b0;
        water_ok = 1'b1; texpired = 1'b0; coffee_sel = 2'd0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_value", value, 0);
        chk("rst_outs", {start_timer, heater_on, pump_on, valve_on, done, error}, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Normal brew, sel=2, start held high for the whole run.
        start_btn = 1'b1; coffee_sel = 2'd2;
        tick();                                   // CHECK
        chk("chk_busy", busy, 1);
        chk("chk_heater", heater_on, 0);
        chk("chk_st", start_timer, 0);
        coffee_sel = 2'd0;                        // sel already latched
        tick();                                   // HEAT c1
        chk("heat_st", start_timer, 1);
        chk("heat_val", value, 20);
        chk("heat_act", {heater_on, pump_on, valve_on}, 3'b100);
        water_ok = 1'b0;                          // must not abort
        tick();                                   // HEAT c2
        chk("heat_st_c2", start_timer, 0);
        chk("heat_val_c2", value, 20);
        texpired = 1'b1;
        tick();                                   // HEAT c3, expiry ignored
        chk("heat_guard", {heater_on, pump_on}, 2'b10);
        chk("heat_val_c3", value, 20);
        tick();                                   // BREW c1
        chk("brew_st", start_timer, 1);
        chk("brew_val", value, 60);
        chk("brew_act", {heater_on, pump_on, valve_on}, 3'b110);
        texpired = 1'b0;
        tick(); tick(); tick(); tick();           // still BREW, no expiry
        chk("brew_hold", {pump_on, start_timer}, 2'b10);
        chk("brew_val_hold", value, 60);
        texpired = 1'b1;
        tick();                                   // DISP c1
        chk("disp_st", start_timer, 1);
        chk("disp_val", value, 10);
        chk("disp_act", {heater_on, pump_on, valve_on}, 3'b001);
        tick(); tick();                           // DISP c2, c3
        chk("disp_c3", valve_on, 1);
        tick();                                   // IDLE
        chk("done_pulse", done, 1);
        chk("idle_busy", busy, 0);
        chk("idle_outs", {valve_on, value}, 0);
        tick();
        chk("done_once", done, 0);
        tick(); tick();
        chk("held_no_retrig", busy, 0);
        texpired = 1'b0;

        // Second brew after a new edge; cancel and expiry together in BREW.
        water_ok = 1'b1; coffee_sel = 2'd1;
        start_btn = 1'b0; tick();
        start_btn = 1'b1; texpired = 1'b1;
        tick();                                   // CHECK
        chk("re_edge_busy", busy, 1);
        tick(); tick(); tick();                   // HEAT c1..c3
        tick();                                   // BREW c1
        chk("brew2_val", value, 45);
        tick(); tick();                           // BREW c3
        cancel_btn = 1'b1;
        tick();
        chk("cancel_act", {heater_on, pump_on, valve_on}, 0);
        chk("cancel_busy", busy, 0);
        chk("cancel_done", {done, start_timer}, 0);
        cancel_btn = 1'b0; texpired = 1'b0;
        tick();
        chk("cancel_no_disp", {valve_on, done, busy}, 0);

        // No water: ERROR, start ignored, cancel clears.
        start_btn = 1'b0; tick();
        water_ok = 1'b0; start_btn = 1'b1;
        tick();                                   // CHECK
        tick();                                   // ERROR
        chk("err_flag", error, 1);
        chk("err_busy_act", {busy, heater_on, pump_on, valve_on}, 0);
        start_btn = 1'b0; tick();
        start_btn = 1'b1; tick(); tick();
        chk("err_start_ign", {error, busy}, 2'b10);
        cancel_btn = 1'b1; tick();
        chk("err_exit", error, 0);
        cancel_btn = 1'b0; tick();
        chk("err_idle", {error, busy}, 0);

        // Held texpired: every timed stage lasts three cycles.
        water_ok = 1'b1; coffee_sel = 2'd3;
        start_btn = 1'b0; tick();
        start_btn = 1'b1; texpired = 1'b1;
        n_st = 0; n_heat = 0; n_brew = 0; n_disp = 0; n_busy = 0; n_done = 0;
        brew_val = 8'd0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (start_timer) n_st++;
            if (heater_on && !pump_on) n_heat++;
            if (heater_on && pump_on) begin
                n_brew++;
                if (start_timer) brew_val = value;
            end
            if (valve_on) n_disp++;
            if (busy) n_busy++;
            if (done) n_done++;
        end
        chk("run_st_pulses", n_st, 3);
        chk("run_heat_cyc", n_heat, 3);
        chk("run_brew_cyc", n_brew, 3);
        chk("run_disp_cyc", n_disp, 3);
        chk("run_busy_cyc", n_busy, 10);
        chk("run_done", n_done, 1);
        chk("run_brew_val", brew_val, 90);
        texpired = 1'b0;

        // Asynchronous reset in the middle of HEAT.
        start_btn = 1'b0; tick();
        start_btn = 1'b1;
        tick();                                   // CHECK
        tick();                                   // HEAT
        chk("pre_rst_heat", heater_on, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_heater", heater_on, 0);
        chk("async_busy", busy, 0);
        chk("async_value", value, 0);
        start_btn = 1'b0;
        tick(); tick();
        chk("rst_no_done", done, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {busy, done}, 0);
        start_btn = 1'b1;
        tick();
        chk("post_rst_resume", busy, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/brew_sequencer.md
BREW_SEQUENCER -- requirements
Module: brew_sequencer

Interface
REQ-001 Parameter VAL_W, default 8, width of the timer load value.
REQ-002 Parameter T_HEAT, default 20, heat-stage timer load.
REQ-003 Parameter T_DISP, default 10, dispense-stage timer load.
REQ-004 clk_100MHz  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start_btn  input  1  brew request; level input, rising edge acts.
REQ-007 cancel_btn  input  1  abort/clear request; level, sampled every cycle.
REQ-008 coffee_sel  input  2  brew strength select.
REQ-009 water_ok  input  1  tank level sensor, 1 = sufficient water.
REQ-010 texpired  input  1  timer expiry flag from the temporizador.
REQ-011 start_timer  output  1  one-cycle timer start pulse.
REQ-012 value  output  VAL_W  timer load value.
REQ-013 heater_on, pump_on, valve_on  output  1 each  actuator enables.
REQ-014 busy  output  1  high in CHECK, HEAT, BREW or DISP.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 error  output  1  high while in ERROR.

Function
REQ-017 States SHALL be IDLE, CHECK, HEAT, BREW, DISP, ERROR; all outputs SHALL be registered.
REQ-018 IDLE->CHECK on a start_btn rising edge (previous-cycle sample 0, current 1); coffee_sel SHALL be latched in the same cycle.
REQ-019 CHECK SHALL last one cycle: water_ok=1 -> HEAT; water_ok=0 -> ERROR.
REQ-020 Brew load from latched sel: 0->30, 1->45, 2->60, 3->90 (truncated to VAL_W).
REQ-021 On entry to HEAT, BREW and DISP: value loads T_HEAT, the brew load, or T_DISP respectively; start_timer SHALL be 1 in the first cycle of the state only; value SHALL be held stable for the whole state.
REQ-022 texpired SHALL be ignored in the first two cycles of each timed state; thereafter texpired=1 advances HEAT->BREW->DISP->IDLE.
REQ-023 Actuators: HEAT heater_on; BREW heater_on+pump_on; DISP valve_on; all 0 in other states.
REQ-024 done SHALL pulse 1 for exactly the first cycle back in IDLE after DISP expiry.
REQ-025 cancel_btn=1 in CHECK/HEAT/BREW/DISP -> IDLE next cycle, actuators 0, no done, no start_timer.
REQ-026 cancel_btn and texpired in the same cycle: cancel wins.
REQ-027 ERROR: error=1, actuators 0; exits to IDLE only on cancel_btn=1; start_btn ignored.
REQ-028 start_btn edges outside IDLE SHALL be ignored; a held start_btn SHALL NOT retrigger after return to IDLE.
REQ-029 water_ok is checked only in CHECK; later deassertion does not abort.

Reset
REQ-030 rst_n=0 SHALL immediately force IDLE, start_timer=0, value=0, all actuators 0, busy=0, done=0, error=0, latched sel=0, edge register=0.
REQ-031 Reset mid-brew SHALL abort without a done pulse; operation resumes on the first clock edge after rst_n=1.

Verification
REQ-032 water_ok=1, sel=2, start edge at cycle N -> CHECK N+1, HEAT N+2 with start_timer=1/value=20, texpired -> BREW value=60 start_timer pulse, texpired -> DISP value=10, texpired -> IDLE, done=1 for one cycle.
REQ-033 water_ok=0, start edge -> CHECK then ERROR, error=1, actuators 0; start edge ignored; cancel_btn -> IDLE, error=0.
REQ-034 texpired held 1 throughout a run -> each timed state lasts exactly 3 cycles; start_timer pulses exactly 3 times.
REQ-035 cancel_btn and texpired both 1 in BREW -> IDLE, pump_on=0, done=0, no DISP entry.
REQ-036 rst_n=0 asynchronously mid-HEAT -> heater_on=0 and busy=0 before the next clock edge; no done pulse.
REQ-037 start_btn held high across a full run -> exactly one brew; next brew only after a 0->1 transition.
